// File: rtl/bcd_sub_seq_if.sv
// Start/done handshake bundle for the digit-serial BCD subtractor.
// Master drives operands and start; slave returns result and status.
interface bcd_sub_seq_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   A;
  logic [4*DIGITS-1:0]   B;
  logic [4*DIGITS-1:0]   Result;
  logic                  Negative;
  logic                  Invalid;
  logic                  busy;
  logic                  done;

  modport master (
    output start, A, B,
    input  Result, Negative, Invalid, busy, done
  );

  modport slave (
    input  start, A, B,
    output Result, Negative, Invalid, busy, done
  );
endinterface

// File: rtl/bcd_sub_seq.sv
// Digit-serial packed-BCD subtractor: |A-B| plus sign, LSD first.
// A negative raw difference is fixed by a ten's-complement pass.
module bcd_sub_seq #(
  parameter int DIGITS = 4
) (
  input  logic          clk,
  input  logic          rst,
  bcd_sub_seq_if.slave  bus
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SUB,
    S_FIX,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    res_q, res_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            bor_q, bor_d;
  logic            neg_q, neg_d;
  logic            inv_q, inv_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [3:0]        a_dig, b_dig, r_dig;
  logic [3:0]        opx, opy, dig;
  logic signed [4:0] t;
  logic              bor_n;
  logic              last;

  function automatic logic has_bad(input logic [W-1:0] v);
    has_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9)
        has_bad = 1'b1;
  endfunction

  // Current digit select and one-digit subtract with borrow
  always_comb begin
    a_dig = 4'd0;
    b_dig = 4'd0;
    r_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++)
      if (idx_q == IW'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
        r_dig = res_q[4*i +: 4];
      end
    opx   = (state_q == S_FIX) ? 4'd0 : a_dig;
    opy   = (state_q == S_FIX) ? r_dig : b_dig;
    t     = $signed({1'b0, opx})
          - $signed({1'b0, opy})
          - $signed({4'd0, bor_q});
    bor_n = t[4];
    dig   = bor_n ? (t[3:0] + 4'd10) : t[3:0];
    last  = (idx_q == IW'(DIGITS - 1));
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    idx_d   = idx_q;
    bor_d   = bor_q;
    neg_d   = neg_q;
    inv_d   = inv_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_d   = bus.A;
          b_d   = bus.B;
          idx_d = '0;
          bor_d = 1'b0;
          neg_d = 1'b0;
          inv_d = 1'b0;
          res_d = '0;
          if (has_bad(bus.A) || has_bad(bus.B)) begin
            inv_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_SUB;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_SUB, S_FIX: begin
        for (int i = 0; i < DIGITS; i++)
          if (idx_q == IW'(i))
            res_d[4*i +: 4] = dig;
        bor_d = bor_n;
        idx_d = last ? '0 : idx_q + IW'(1);
        if (last) begin
          if (state_q == S_SUB && bor_n) begin
            bor_d   = 1'b0;
            neg_d   = 1'b1;
            state_d = S_FIX;
          end else begin
            // Final FIX borrow is meaningless and dropped
            bor_d   = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_SUB) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // State and output registers, async clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      bor_q   <= 1'b0;
      neg_q   <= 1'b0;
      inv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      bor_q   <= bor_d;
      neg_q   <= neg_d;
      inv_q   <= inv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.Result   = res_q;
  assign bus.Negative = neg_q;
  assign bus.Invalid  = inv_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_bcd_sub_seq.sv
// Directed bench for bcd_sub_seq with hand-computed vectors.
// Covers latency, FIX pass, invalid input, protocol and reset.
module tb_bcd_sub_seq;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  bcd_sub_seq_if #(.DIGITS(4)) bus ();

  bcd_sub_seq #(.DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits for done from cycle count c0; bounded
  task automatic wait_done(
    input  int          c0,
    input  bit          chk_raw,
    input  logic [15:0] exp_raw,
    output int          c,
    output int          nb
  );
    c  = c0;
    nb = 0;
    while (!bus.done && c < 40) begin
      if (bus.busy) nb++;
      if (chk_raw && c == 5) chk("raw", bus.Result, exp_raw);
      @(negedge clk);
      c++;
    end
  endtask

  task automatic run_op(
    input string       tag,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [15:0] er,
    input logic        en,
    input logic        ei,
    input int          el,
    input bit          chk_raw,
    input logic [15:0] exp_raw
  );
    int c;
    int nb;
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(1, chk_raw, exp_raw, c, nb);
    chk({tag, "_lat"}, c, el);
    chk({tag, "_busy"}, nb, el - 1);
    chk({tag, "_res"}, bus.Result, er);
    chk({tag, "_neg"}, bus.Negative, en);
    chk({tag, "_inv"}, bus.Invalid, ei);
    @(negedge clk);
    chk({tag, "_pulse"}, bus.done, 0);
  endtask

  initial begin
    int c;
    int nb;
    int nd;
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (2) @(negedge clk);
    chk("rst_res", bus.Result, 0);
    chk("rst_neg", bus.Negative, 0);
    chk("rst_inv", bus.Invalid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;

    run_op("basic", 16'h0045, 16'h0012, 16'h0033, 0, 0, 5, 0, 16'h0);
    run_op("ripple", 16'h1000, 16'h0001, 16'h0999, 0, 0, 5, 0, 16'h0);
    run_op("neg", 16'h0012, 16'h0045, 16'h0033, 1, 0, 9, 1, 16'h9967);
    run_op("neg9", 16'h0000, 16'h9999, 16'h9999, 1, 0, 9, 1, 16'h0001);
    run_op("neg3", 16'h0001, 16'h1000, 16'h0999, 1, 0, 9, 1, 16'h9001);
    run_op("eq", 16'h9999, 16'h9999, 16'h0000, 0, 0, 5, 0, 16'h0);
    run_op("small", 16'h0100, 16'h0099, 16'h0001, 0, 0, 5, 0, 16'h0);
    run_op("inv", 16'h00A1, 16'h0001, 16'h0000, 0, 1, 1, 0, 16'h0);
    run_op("invb", 16'h0001, 16'hF000, 16'h0000, 0, 1, 1, 0, 16'h0);

    // start during SUB is ignored
    @(negedge clk);
    bus.A     = 16'h0045;
    bus.B     = 16'h0012;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.A     = 16'h0999;
    bus.B     = 16'h0111;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(3, 0, 16'h0, c, nb);
    chk("ign_lat", c, 5);
    chk("ign_res", bus.Result, 16'h0033);
    chk("ign_neg", bus.Negative, 0);

    // start held through DONE: back-to-back, no IDLE gap
    @(negedge clk);
    @(negedge clk);
    bus.A     = 16'h1000;
    bus.B     = 16'h0001;
    bus.start = 1'b1;
    @(negedge clk);
    wait_done(1, 0, 16'h0, c, nb);
    chk("b2b1_lat", c, 5);
    chk("b2b1_res", bus.Result, 16'h0999);
    bus.A = 16'h0045;
    bus.B = 16'h0012;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_gap", bus.busy, 1);
    wait_done(1, 0, 16'h0, c, nb);
    chk("b2b2_lat", c, 5);
    chk("b2b2_res", bus.Result, 16'h0033);

    // async reset in the middle of FIX
    @(negedge clk);
    @(negedge clk);
    bus.A     = 16'h0012;
    bus.B     = 16'h0045;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("fix_busy", bus.busy, 1);
    chk("fix_neg", bus.Negative, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_res", bus.Result, 0);
    chk("arst_neg", bus.Negative, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b0;
    nd  = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("arst_nodone", nd, 0);
    run_op("post", 16'h0012, 16'h0045, 16'h0033, 1, 0, 9, 1, 16'h9967);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
